// File: rtl/pc_pkg.sv
// Shared definitions for the PC fetch unit: FSM state encoding, default
// width/reset constants and a small alignment helper.
package pc_pkg;

  // Default datapath width and reset address.
  localparam int         PC_WIDTH_DEFAULT = 8;
  localparam logic [7:0] PC_RESET_DEFAULT = 8'h00;

  // Fetch FSM state encoding.
  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE  = 2'd0;
  localparam fsm_state_t ST_FETCH = 2'd1;
  localparam fsm_state_t ST_STALL = 2'd2;

  // A word-aligned address has its two low bits clear.
  function automatic logic is_misaligned(input logic [1:0] lsbs);
    return (lsbs != 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority selector:
// live jump > live branch > pending redirect > sequential pc_plus4.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH_DEFAULT
) (
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             pend_valid,
  input  logic [WIDTH-1:0] pend_target,
  input  logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] next_pc
);

  // Pick the highest-priority source of the next fetch address.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end else if (pend_valid) begin
      next_pc = pend_target;
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC fetch unit: IDLE/FETCH/STALL FSM, PC register, pending-redirect
// capture and the pc_valid pulse. All outputs come straight from flops.
// Optional feature: define PC_ALIGN_CHECK_EN to force redirect targets to
// word alignment and raise a sticky align_fault on a misaligned target.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH    = PC_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_PC = PC_RESET_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             stall,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic             align_fault
);

  fsm_state_t       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             imem_req_q, imem_req_d;
  logic             pc_valid_q, pc_valid_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;

  logic             accept;
  logic             load;
  logic [WIDTH-1:0] sel_pc;
  logic [WIDTH-1:0] load_pc;

  pc_next_sel #(
    .WIDTH(WIDTH)
  ) u_next_sel (
    .jump         (jump),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .pend_valid   (pend_valid_q),
    .pend_target  (pend_target_q),
    .pc_plus4     (pc_plus4),
    .next_pc      (sel_pc)
  );

  // A fetch is accepted when a request meets a ready memory; it only
  // advances the PC when the pipeline is not stalled.
  always_comb begin
    accept = imem_req_q & imem_ready;
    load   = accept & ~stall;
  end

`ifdef PC_ALIGN_CHECK_EN
  logic redirect_sel;
  logic misaligned;
  logic align_fault_q, align_fault_d;

  // Word-align redirect targets and flag any that arrive misaligned.
  always_comb begin
    redirect_sel = jump | branch_taken | pend_valid_q;
    misaligned   = redirect_sel & is_misaligned(sel_pc[1:0]);
    if (redirect_sel) begin
      load_pc = {sel_pc[WIDTH-1:2], 2'b00};
    end else begin
      load_pc = sel_pc;
    end
    if (load && misaligned) begin
      align_fault_d = 1'b1;
    end else begin
      align_fault_d = align_fault_q;
    end
  end

  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_fault_q <= 1'b0;
    end else begin
      align_fault_q <= align_fault_d;
    end
  end

  assign align_fault = align_fault_q;
`else
  // Targets load exactly as presented when alignment checking is off.
  always_comb begin
    load_pc = sel_pc;
  end

  assign align_fault = 1'b0;
`endif

  // Next-state, PC, pending-redirect and output-flop computation.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (accept && stall) begin
          state_d = ST_STALL;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_STALL: begin
        if (!stall) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_STALL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load) begin
      pc_d = load_pc;
    end else begin
      pc_d = pc_q;
    end

    // The pending redirect is consumed by a non-stalled accept; otherwise
    // the newest redirect overwrites it, jump taking precedence.
    if (load) begin
      pend_valid_d  = 1'b0;
      pend_target_d = pend_target_q;
    end else if (jump) begin
      pend_valid_d  = 1'b1;
      pend_target_d = jump_target;
    end else if (branch_taken) begin
      pend_valid_d  = 1'b1;
      pend_target_d = branch_target;
    end else begin
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
    end

    imem_req_d = (state_d == ST_FETCH);
    pc_valid_d = (pc_d != pc_q);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      imem_req_q    <= 1'b0;
      pc_valid_q    <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      imem_req_q    <= imem_req_d;
      pc_valid_q    <= pc_valid_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign pc       = pc_q;
  assign imem_req = imem_req_q;
  assign pc_valid = pc_valid_q;

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter WIDTH, default 8, PC and address width in bits.
REQ-002 Parameter RESET_PC, default 8'h00, PC value loaded on reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 pc_plus4  input  WIDTH  sequential next address from the downstream +4 adder; its A input is driven by pc.
REQ-006 branch_taken  input  1  branch redirect request.
REQ-007 branch_target  input  WIDTH  branch destination.
REQ-008 jump  input  1  jump redirect request.
REQ-009 jump_target  input  WIDTH  jump destination.
REQ-010 stall  input  1  pipeline hazard hold.
REQ-011 imem_ready  input  1  instruction memory accepts the current request.
REQ-012 imem_req  output  1  fetch request for address pc.
REQ-013 pc  output  WIDTH  current fetch address.
REQ-014 pc_valid  output  1  one-cycle pulse: pc was just updated by an accepted fetch.
REQ-015 align_fault  output  1  sticky misaligned-target flag.

Function
REQ-016 The unit SHALL implement FSM states IDLE, FETCH, STALL.
REQ-017 IDLE SHALL last exactly one cycle after reset release, with imem_req=0, then enter FETCH.
REQ-018 In FETCH imem_req SHALL be 1; a fetch is accepted on a cycle with imem_req=1 and imem_ready=1.
REQ-019 On accept with stall=0, pc SHALL load the next address, priority: live jump > live branch_taken > pending redirect > pc_plus4.
REQ-020 On accept with stall=1, pc SHALL hold, state SHALL go to STALL, and imem_req SHALL be 0 from the next cycle.
REQ-021 In FETCH with imem_ready=0, pc and imem_req SHALL hold.
REQ-022 In STALL, stall=0 SHALL return the FSM to FETCH on the next edge, with pc unchanged.
REQ-023 A jump or branch_taken sampled in any state without a non-stalled accept SHALL be captured in a pending-redirect register; a later redirect overwrites it, and jump wins when both occur in the same cycle.
REQ-024 The pending redirect SHALL be consumed and cleared on the next non-stalled accept.
REQ-025 pc_valid SHALL be 1 for exactly the cycle after each cycle in which pc changed, and 0 otherwise.
REQ-026 pc_plus4 wrap-around SHALL be used unmodified: pc 8'hFC advances to 8'h00.
REQ-027 Latency from accept to new pc SHALL be one clock.

Reset
REQ-028 While rst_n=0: pc=RESET_PC, state=IDLE, imem_req=0, pc_valid=0, align_fault=0, pending redirect cleared, all asynchronously.
REQ-029 Reset asserted mid-fetch SHALL discard the in-flight request and the pending redirect.

Configuration
REQ-030 With PC_ALIGN_CHECK_EN defined, a selected redirect target with bits [1:0] != 0 SHALL set align_fault, which stays set until reset; pc SHALL load the target with bits [1:0] forced to 0.
REQ-031 Without PC_ALIGN_CHECK_EN, align_fault SHALL be tied to 0 and targets SHALL load unmodified.

Structure
REQ-032 The shared package pc_pkg SHALL hold the FSM state encoding (IDLE=2'd0, FETCH=2'd1, STALL=2'd2) and the default WIDTH and RESET_PC constants.
REQ-033 The next-PC priority selection SHALL be a sub-module, pc_next_sel; the FSM and registers stay in pc_fetch_unit.

Verification
REQ-034 Reset release, imem_ready=1 held, stall=0, stubbed +4 adder -> pc sequence 00, 04, 08, 0C; imem_req rises in the second cycle after release; pc_valid pulses once per step.
REQ-035 pc=8'hFC, accept -> pc=8'h00 on the next edge.
REQ-036 imem_ready=0 for 3 cycles, jump=1 with jump_target=8'h40 in the first of them, then imem_ready=1 -> pc holds for 3 cycles, then loads 8'h40 on accept; pending redirect cleared.
REQ-037 Same cycle: jump=1 (jump_target=8'h20), branch_taken=1 (branch_target=8'h30), accept -> pc=8'h20.
REQ-038 stall=1 on accept at pc=8'h08 for 2 cycles -> FSM in STALL, imem_req=0, pc=8'h08; stall drops -> FETCH, imem_req=1.
REQ-039 With PC_ALIGN_CHECK_EN, branch_target=8'h13 accepted -> pc=8'h10, align_fault=1 held until rst_n=0.
